// File: rtl/binary_decoder_scan_if.sv
// ---------------------------------------------------------------------------
// binary_decoder_scan_if
//   Bundles the control inputs and LED/status outputs of binary_decoder_scan.
//
//   Parameter:
//     SEL_W : select width; the LED bus is 2^SEL_W bits wide.
//
//   Signals:
//     en   : enable; 0 blanks the LEDs and freezes the sequencer
//     mode : 00 direct, 01 scan up, 10 scan down, 11 bounce
//     a    : direct select / load value
//     load : single-cycle pulse, sel <= a
//     led  : registered one-hot LED bus
//     sel  : current registered select index
//     wrap : single-cycle pulse on wrap or direction reversal
//
//   Modports:
//     master : control side (drives en/mode/a/load, observes led/sel/wrap)
//     slave  : the decoder itself
// ---------------------------------------------------------------------------
interface binary_decoder_scan_if #(
  parameter int SEL_W = 3
);
  localparam int LED_W = 1 << SEL_W;

  logic             en;
  logic [1:0]       mode;
  logic [SEL_W-1:0] a;
  logic             load;
  logic [LED_W-1:0] led;
  logic [SEL_W-1:0] sel;
  logic             wrap;

  modport master (
    output en, mode, a, load,
    input  led, sel, wrap
  );

  modport slave (
    input  en, mode, a, load,
    output led, sel, wrap
  );
endinterface

// File: rtl/binary_decoder_scan.sv
// ---------------------------------------------------------------------------
// binary_decoder_scan
//   Registered N-to-2^N one-hot LED decoder with a prescaled sequencer that
//   can walk the lit LED up, down or back-and-forth (bounce).
//
//   Parameters:
//     SEL_W    : select width, 1..6; LED bus is 2^SEL_W bits
//     PRESCALE : clock cycles per scan step, >= 1 (1 = step every cycle)
//
//   Ports:
//     clk   : system clock, rising edge
//     rst_n : asynchronous active-low reset
//     bus   : binary_decoder_scan_if.slave (en, mode, a, load -> led, sel, wrap)
//
//   Build option:
//     LED_ACTIVE_LOW_EN : when defined the LED bus is driven inverted
//                         (lit bit = 0, blank/reset = all ones); sel and
//                         wrap are unaffected.
// ---------------------------------------------------------------------------
module binary_decoder_scan #(
  parameter int SEL_W    = 3,
  parameter int PRESCALE = 4
) (
  input logic                  clk,
  input logic                  rst_n,
  binary_decoder_scan_if.slave bus
);

  localparam int LED_W  = 1 << SEL_W;
  localparam int PCNT_W = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;

  localparam logic [SEL_W-1:0]  SEL_ZERO  = {SEL_W{1'b0}};
  localparam logic [SEL_W-1:0]  SEL_MAX   = {SEL_W{1'b1}};
  localparam logic [SEL_W-1:0]  SEL_ONE   = SEL_W'(1);
  localparam logic [PCNT_W-1:0] PCNT_ZERO = {PCNT_W{1'b0}};
  localparam logic [PCNT_W-1:0] PCNT_ONE  = PCNT_W'(1);
  localparam logic [PCNT_W-1:0] PCNT_LAST = PCNT_W'(PRESCALE - 1);
  localparam logic [LED_W-1:0]  LED_ONE   = {{(LED_W-1){1'b0}}, 1'b1};

`ifdef LED_ACTIVE_LOW_EN
  localparam logic [LED_W-1:0] LED_BLANK = {LED_W{1'b1}};
`else
  localparam logic [LED_W-1:0] LED_BLANK = {LED_W{1'b0}};
`endif

  typedef enum logic [1:0] {
    MODE_DIRECT = 2'b00,
    MODE_UP     = 2'b01,
    MODE_DOWN   = 2'b10,
    MODE_BOUNCE = 2'b11
  } mode_e;

  typedef enum logic {
    DIR_UP   = 1'b0,
    DIR_DOWN = 1'b1
  } dir_e;

  typedef struct packed {
    logic [SEL_W-1:0] sel;
    dir_e             dir;
    logic             wrap;
  } step_t;

  // Parameter legality is only checked in simulation.
  initial begin
    if ((SEL_W < 1) || (SEL_W > 6)) begin
      $error("binary_decoder_scan: SEL_W=%0d outside 1..6", SEL_W);
    end
    if (PRESCALE < 1) begin
      $error("binary_decoder_scan: PRESCALE=%0d must be >= 1", PRESCALE);
    end
  end

  // One scan step from index s in mode m; wrap flags a wrap-around or a
  // bounce reversal. Direct mode never steps, so it returns s unchanged.
  function automatic step_t scan_step(input mode_e m,
                                      input logic [SEL_W-1:0] s,
                                      input dir_e d);
    step_t r;
    r.sel  = s;
    r.dir  = d;
    r.wrap = 1'b0;
    case (m)
      MODE_UP: begin
        r.sel  = s + SEL_ONE;
        r.wrap = (s == SEL_MAX);
      end
      MODE_DOWN: begin
        r.sel  = s - SEL_ONE;
        r.wrap = (s == SEL_ZERO);
      end
      MODE_BOUNCE: begin
        if (d == DIR_UP) begin
          if (s == SEL_MAX) begin
            r.sel  = s - SEL_ONE;
            r.dir  = DIR_DOWN;
            r.wrap = 1'b1;
          end else begin
            r.sel  = s + SEL_ONE;
          end
        end else begin
          if (s == SEL_ZERO) begin
            r.sel  = s + SEL_ONE;
            r.dir  = DIR_UP;
            r.wrap = 1'b1;
          end else begin
            r.sel  = s - SEL_ONE;
          end
        end
      end
      default: begin
        r.sel = s;
      end
    endcase
    return r;
  endfunction

  // LED pattern for index s, blanked when not enabled, in board polarity.
  function automatic logic [LED_W-1:0] led_drive(input logic [SEL_W-1:0] s,
                                                 input logic on);
    logic [LED_W-1:0] pat;
    if (on) begin
      pat = LED_ONE << s;
    end else begin
      pat = {LED_W{1'b0}};
    end
`ifdef LED_ACTIVE_LOW_EN
    return ~pat;
`else
    return pat;
`endif
  endfunction

  logic [SEL_W-1:0]  sel_r;
  logic [LED_W-1:0]  led_r;
  logic              wrap_r;
  logic [PCNT_W-1:0] pcnt_r;
  dir_e              dir_r;
  mode_e             mode_r;

  logic [SEL_W-1:0]  sel_nxt_s;
  logic              wrap_nxt_s;
  logic [PCNT_W-1:0] pcnt_nxt_s;
  dir_e              dir_nxt_s;
  mode_e             mode_nxt_s;
  mode_e             mode_in_s;
  logic              tick_s;
  step_t             step_s;

  assign mode_in_s = mode_e'(bus.mode);
  assign tick_s    = bus.en & (pcnt_r == PCNT_LAST);
  assign step_s    = scan_step(mode_r, sel_r, dir_r);

  // Next-state selection; branch order is the edge priority
  // (load, disable, mode change, direct, tick, count).
  always_comb begin
    sel_nxt_s  = sel_r;
    dir_nxt_s  = dir_r;
    mode_nxt_s = mode_r;
    pcnt_nxt_s = pcnt_r;
    wrap_nxt_s = 1'b0;
    if (bus.load) begin
      // Load wins over a coincident tick and works while disabled.
      sel_nxt_s  = bus.a;
      pcnt_nxt_s = PCNT_ZERO;
    end else if (!bus.en) begin
      pcnt_nxt_s = PCNT_ZERO;
    end else if (mode_in_s != mode_r) begin
      // A mode switch only restarts the prescaler; no step this edge.
      mode_nxt_s = mode_in_s;
      pcnt_nxt_s = PCNT_ZERO;
      if (mode_in_s == MODE_BOUNCE) begin
        dir_nxt_s = (sel_r == SEL_MAX) ? DIR_DOWN : DIR_UP;
      end else begin
        dir_nxt_s = dir_r;
      end
    end else if (mode_r == MODE_DIRECT) begin
      sel_nxt_s  = bus.a;
      pcnt_nxt_s = PCNT_ZERO;
    end else if (tick_s) begin
      sel_nxt_s  = step_s.sel;
      dir_nxt_s  = step_s.dir;
      wrap_nxt_s = step_s.wrap;
      pcnt_nxt_s = PCNT_ZERO;
    end else begin
      pcnt_nxt_s = pcnt_r + PCNT_ONE;
    end
  end

  // State and output registers; led is built from the next sel so that it
  // changes in the same cycle as sel.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sel_r  <= SEL_ZERO;
      led_r  <= LED_BLANK;
      wrap_r <= 1'b0;
      pcnt_r <= PCNT_ZERO;
      dir_r  <= DIR_UP;
      mode_r <= MODE_DIRECT;
    end else begin
      sel_r  <= sel_nxt_s;
      led_r  <= led_drive(sel_nxt_s, bus.en);
      wrap_r <= wrap_nxt_s;
      pcnt_r <= pcnt_nxt_s;
      dir_r  <= dir_nxt_s;
      mode_r <= mode_nxt_s;
    end
  end

  assign bus.led  = led_r;
  assign bus.sel  = sel_r;
  assign bus.wrap = wrap_r;

endmodule

// File: doc/binary_decoder_scan.md
Name: binary_decoder_scan

Overview:
Registered, parametrised successor to the team's 3-to-8 LED decoder. Decodes an N-bit select to a 2^N one-hot LED bus. Adds an internal prescaled sequencer that can walk the lit LED up, down or back-and-forth. Sits between board switches/control logic and the LED bank.

Parameters:
SEL_W, 3, select width; output width is 2^SEL_W; legal range 1..6
PRESCALE, 4, clock cycles per scan step; legal range >=1 (1 = step every cycle)

Ports:
clk  input  1  system clock, rising edge
rst_n  input  1  asynchronous active-low reset
en  input  1  enable; 0 blanks LEDs and freezes sequencer
mode  input  2  00 direct, 01 scan up, 10 scan down, 11 bounce
a  input  SEL_W  direct select / load value
load  input  1  single-cycle pulse: sel <= a
led  output  2^SEL_W  registered one-hot LED bus
sel  output  SEL_W  current registered select index
wrap  output  1  single-cycle pulse on wrap or direction reversal

Behaviour:
- Reset (rst_n=0, async, immediate): sel=0, led=0, wrap=0, prescaler=0, dir=up, stored mode=00.
- All outputs registered; led always equals onehot(sel) when the registered enable is 1, else 0, in the same cycle as sel.
- Prescaler pcnt counts 0..PRESCALE-1 while en=1 and mode!=00. tick = en & (pcnt==PRESCALE-1); pcnt wraps to 0 on tick.
- Priority per edge, highest first: reset, load, en=0, mode change, tick, hold.
- load=1: sel<=a, pcnt<=0, wrap<=0. Honoured even when en=0; led stays 0 in that case. Overrides a coincident tick.
- en=0: led<=0 on the next edge, sel and dir hold, pcnt<=0, wrap<=0.
- Mode change (mode != stored mode): pcnt<=0, no step that cycle. Entering bounce sets dir=up, or dir=down if sel==2^SEL_W-1.
- Direct (00), en=1: sel<=a every edge (1-cycle latency a->led). pcnt held at 0. wrap always 0.
- Scan up (01): on tick sel<=sel+1. At max (2^SEL_W-1), sel wraps to 0 and wrap=1 for one cycle.
- Scan down (10): on tick sel<=sel-1. At 0, sel wraps to max and wrap=1.
- Bounce (11): on tick, step in dir.
  - At max with dir=up: sel<=max-1, dir<=down, wrap=1.
  - At 0 with dir=down: sel<=1, dir<=up, wrap=1.
  - SEL_W=1: toggles 0/1 with wrap on every step.
- wrap is 0 in every cycle not listed above. Never two consecutive wrap cycles unless PRESCALE=1.
- Arithmetic modulo 2^SEL_W. pcnt width = clog2(PRESCALE), minimum 1.
- Illegal parameters are flagged with a simulation-time error in an initial block.

Optional Feature:
LED_ACTIVE_LOW_EN
- Defined: led driven inverted (lit bit = 0, blank = all ones), reset value all ones; sel and wrap unchanged.
- Undefined: active-high as described above.

Test Plan:
1. SEL_W=3, PRESCALE=4; rst_n=1, en=1, mode=00, sweep a=0..7 one per cycle -> led=8'h01,02,..,80 each one edge after a; sel=a; wrap=0 throughout.
2. Scan up: load a=6, then mode=01 -> led=8'h40 for 4 cycles, 8'h80 for 4 cycles, then 8'h01 with wrap=1 for exactly that one cycle.
3. Bounce from load a=0 -> sel sequence 0,1..7,6..0,1, each held 4 cycles; wrap pulses at 7->6 and 0->1 only.
4. Scan down; drop en for 3 cycles mid-step at pcnt=2 -> led=0 next edge, sel holds. After en returns, 4 full cycles pass before the next decrement.
5. load a=5 coincident with a tick in mode 01 -> sel=5 (not sel+1), wrap=0, pcnt=0.
6. Async reset asserted mid-cycle during scan at sel=3 -> led=0, sel=0, wrap=0 immediately, before the next clk edge. After release, first step occurs 4 cycles later.
